// File: rtl/frame_capture_pkg.sv
// -----------------------------------------------------------------------------
// frame_capture_pkg
// Shared definitions for the frame capture controller slice.
//   state_e    : controller states (IDLE, ARM, CAPTURE)
//   cnt_width  : width helper for the pixel/line counters, never below 1 bit
// -----------------------------------------------------------------------------
package frame_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  // A dimension of 1 still needs a 1-bit counter so that the compare
  // against (dimension - 1) stays well formed.
  function automatic int cnt_width(input int n);
    if (n <= 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/frame_capture_ctrl_pix_line_counter.sv
// -----------------------------------------------------------------------------
// pix_line_counter
// Column/row position counters for one frame. The counters hold the position
// of the next pixel to arrive.
//   i_Sys_clk   : system clock
//   i_Rst       : asynchronous active-high reset
//   clear       : restart the frame at pixel 0 (this cycle's beat, if any, is pixel 0)
//   advance     : a pixel beat is consumed this cycle
//   first_pix   : position is column 0, row 0 (only with FRAME_CAPTURE_CTRL_MARKERS_EN)
//   last_col    : position is column IMAGE_WIDTH-1
//   last_pix    : position is the last pixel of the frame
// -----------------------------------------------------------------------------
module pix_line_counter
  import frame_capture_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 512
) (
  input  logic i_Sys_clk,
  input  logic i_Rst,
  input  logic clear,
  input  logic advance,
`ifdef FRAME_CAPTURE_CTRL_MARKERS_EN
  output logic first_pix,
`endif
  output logic last_col,
  output logic last_pix
);

  localparam int COL_W = cnt_width(IMAGE_WIDTH);
  localparam int ROW_W = cnt_width(IMAGE_HEIGHT);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMAGE_HEIGHT - 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] base_col;
  logic [ROW_W-1:0] base_row;
  logic [COL_W-1:0] next_col;
  logic [ROW_W-1:0] next_row;

  // A clear rebases the position to pixel 0 before the beat (if any) of
  // the same cycle is counted, so a coincident beat lands on pixel 0.
  // The column wraps at the last column and carries into the row; the row
  // wraps at the last line so a completed frame leaves the counters at 0.
  always_comb begin
    base_col = clear ? '0 : col;
    base_row = clear ? '0 : row;
    next_col = base_col;
    next_row = base_row;
    if (advance) begin
      if (base_col == LAST_COL) begin
        next_col = '0;
        if (base_row == LAST_ROW) begin
          next_row = '0;
        end else begin
          next_row = base_row + ROW_W'(1);
        end
      end else begin
        next_col = base_col + COL_W'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= next_col;
      row <= next_row;
    end
  end

  // Flags describe the registered position, i.e. the pixel that the next
  // beat will be unless a clear intervenes.
  assign last_col = (col == LAST_COL);
  assign last_pix = (col == LAST_COL) && (row == LAST_ROW);
`ifdef FRAME_CAPTURE_CTRL_MARKERS_EN
  assign first_pix = (col == '0) && (row == '0);
`endif

endmodule

// File: rtl/frame_capture_ctrl.sv
// -----------------------------------------------------------------------------
// frame_capture_ctrl
// Waits for frame start after a start command, gates exactly N complete frames
// of IMAGE_WIDTH x IMAGE_HEIGHT pixels from a free-running pixel stream and
// forwards them as a registered valid/data stream. Short frames (vsync before
// the last pixel) set a sticky error and are recaptured.
// Ports:
//   i_Sys_clk, i_Rst       : clock, asynchronous active-high reset
//   i_Start, i_Stop        : capture request / abort
//   i_Frame_num            : frames to capture (0 means 1), sampled on start
//   i_Vsync                : frame-start pulse
//   i_Din_valid, i_Din     : incoming pixel stream
//   o_Dout_valid, o_Dout   : gated pixel stream, 1-cycle latency
//   o_Busy                 : controller not idle
//   o_Done                 : pulse with the final pixel of the last frame
//   o_Frame_idx            : index of the frame being captured
//   o_Err                  : sticky short-frame flag
// Optional macro FRAME_CAPTURE_CTRL_MARKERS_EN adds:
//   o_Sof                  : pixel 0 of a frame, aligned with o_Dout_valid
//   o_Eol                  : last column of a line, aligned with o_Dout_valid
// -----------------------------------------------------------------------------
module frame_capture_ctrl
  import frame_capture_pkg::*;
#(
  parameter int DW           = 16,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 512,
  parameter int FRAME_CNT_W  = 8
) (
  input  logic                   i_Sys_clk,
  input  logic                   i_Rst,
  input  logic                   i_Start,
  input  logic                   i_Stop,
  input  logic [FRAME_CNT_W-1:0] i_Frame_num,
  input  logic                   i_Vsync,
  input  logic                   i_Din_valid,
  input  logic [DW-1:0]          i_Din,
  output logic                   o_Dout_valid,
  output logic [DW-1:0]          o_Dout,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic [FRAME_CNT_W-1:0] o_Frame_idx,
  output logic                   o_Err
`ifdef FRAME_CAPTURE_CTRL_MARKERS_EN
  ,
  output logic                   o_Sof,
  output logic                   o_Eol
`endif
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] ARM     = ST_ARM;
  localparam logic [1:0] CAPTURE = ST_CAPTURE;

  // In a 1x1 frame pixel 0 is also the last pixel; this matters only when
  // a beat arrives together with a counter clear.
  localparam logic ZERO_IS_LAST = (IMAGE_WIDTH == 1) && (IMAGE_HEIGHT == 1);

  logic [1:0]             state;
  logic [1:0]             next_state;
  logic [FRAME_CNT_W-1:0] target;
  logic                   fwd;
  logic                   clear;
  logic                   short_frame;
  logic                   frame_end;
  logic                   last_frame;
  logic                   start_ok;
  logic                   last_col;
  logic                   last_pix;
`ifdef FRAME_CAPTURE_CTRL_MARKERS_EN
  localparam logic ZERO_COL_LAST = (IMAGE_WIDTH == 1);
  logic                   first_pix;
  logic                   sof;
  logic                   eol;
`endif

  pix_line_counter #(
    .IMAGE_WIDTH  (IMAGE_WIDTH),
    .IMAGE_HEIGHT (IMAGE_HEIGHT)
  ) u_counter (
    .i_Sys_clk (i_Sys_clk),
    .i_Rst     (i_Rst),
    .clear     (clear),
    .advance   (fwd),
`ifdef FRAME_CAPTURE_CTRL_MARKERS_EN
    .first_pix (first_pix),
`endif
    .last_col  (last_col),
    .last_pix  (last_pix)
  );

  assign start_ok   = (state == IDLE) && i_Start && !i_Stop;
  assign last_frame = (o_Frame_idx == (target - FRAME_CNT_W'(1)));

  // Per-cycle decisions: which beat is forwarded, when the counters restart,
  // whether this beat finishes a frame and where the FSM goes next. A vsync
  // that lands on the completing beat counts as completion, so a short frame
  // is only declared when the coincident beat is not the last pixel. Stop
  // overrides every other decision, including the beat of its own cycle.
  always_comb begin
    fwd         = 1'b0;
    clear       = 1'b0;
    short_frame = 1'b0;
    frame_end   = 1'b0;
    next_state  = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          next_state = ARM;
        end
      end
      ARM: begin
        if (i_Vsync) begin
          clear      = 1'b1;
          fwd        = i_Din_valid;
          frame_end  = i_Din_valid && ZERO_IS_LAST;
          next_state = CAPTURE;
        end
      end
      CAPTURE: begin
        fwd         = i_Din_valid;
        short_frame = i_Vsync && !(i_Din_valid && last_pix);
        clear       = short_frame;
        frame_end   = i_Din_valid && (short_frame ? ZERO_IS_LAST : last_pix);
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (frame_end) begin
      next_state = last_frame ? IDLE : ARM;
    end
    if (i_Stop) begin
      fwd         = 1'b0;
      clear       = 1'b0;
      short_frame = 1'b0;
      frame_end   = 1'b0;
      next_state  = IDLE;
    end
  end

  // Control registers: state, frame target, frame index, sticky error and
  // the done pulse. An accepted start reloads the target and clears the
  // index and error; stop leaves index and error untouched.
  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) begin
      state       <= IDLE;
      target      <= FRAME_CNT_W'(1);
      o_Frame_idx <= '0;
      o_Err       <= 1'b0;
      o_Done      <= 1'b0;
    end else begin
      state  <= next_state;
      o_Done <= frame_end && last_frame;
      if (start_ok) begin
        target      <= (i_Frame_num == '0) ? FRAME_CNT_W'(1) : i_Frame_num;
        o_Frame_idx <= '0;
        o_Err       <= 1'b0;
      end
      if (short_frame) begin
        o_Err <= 1'b1;
      end
      if (frame_end && !last_frame) begin
        o_Frame_idx <= o_Frame_idx + FRAME_CNT_W'(1);
      end
    end
  end

  // Output pixel stage. Data only updates on forwarded beats so the sink
  // sees the last pixel held between beats.
  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Dout_valid <= 1'b0;
      o_Dout       <= '0;
    end else begin
      o_Dout_valid <= fwd;
      if (fwd) begin
        o_Dout <= i_Din;
      end
    end
  end

  assign o_Busy = (state != IDLE);

`ifdef FRAME_CAPTURE_CTRL_MARKERS_EN
  // Frame/line markers follow the position the forwarded beat lands on; a
  // clear in the same cycle means the beat is pixel 0 of column 0.
  assign sof = clear || first_pix;
  assign eol = clear ? ZERO_COL_LAST : last_col;

  // Marker registers, aligned with o_Dout_valid.
  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Sof <= 1'b0;
      o_Eol <= 1'b0;
    end else begin
      o_Sof <= fwd && sof;
      o_Eol <= fwd && eol;
    end
  end
`endif

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_capture_ctrl
// Self-checking bench for frame_capture_ctrl with a 4x2 frame.
// -----------------------------------------------------------------------------
module tb_frame_capture_ctrl;

  localparam int DW  = 16;
  localparam int W   = 4;
  localparam int H   = 2;
  localparam int FCW = 8;

  logic           i_Sys_clk;
  logic           i_Rst;
  logic           i_Start;
  logic           i_Stop;
  logic [FCW-1:0] i_Frame_num;
  logic           i_Vsync;
  logic           i_Din_valid;
  logic [DW-1:0]  i_Din;
  logic           o_Dout_valid;
  logic [DW-1:0]  o_Dout;
  logic           o_Busy;
  logic           o_Done;
  logic [FCW-1:0] o_Frame_idx;
  logic           o_Err;
`ifdef FRAME_CAPTURE_CTRL_MARKERS_EN
  logic           o_Sof;
  logic           o_Eol;
`endif

  int passCount;
  int checkCount;

  typedef struct {
    logic           start;
    logic           stop;
    logic [FCW-1:0] fnum;
    logic           vsync;
    logic           valid;
    logic [DW-1:0]  din;
    logic           expValid;
    logic [DW-1:0]  expDout;
    logic           expBusy;
    logic           expDone;
    logic [FCW-1:0] expIdx;
    logic           expErr;
  } vec_t;

  vec_t vecs[$];

  frame_capture_ctrl #(
    .DW           (DW),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .FRAME_CNT_W  (FCW)
  ) dut (
    .i_Sys_clk    (i_Sys_clk),
    .i_Rst        (i_Rst),
    .i_Start      (i_Start),
    .i_Stop       (i_Stop),
    .i_Frame_num  (i_Frame_num),
    .i_Vsync      (i_Vsync),
    .i_Din_valid  (i_Din_valid),
    .i_Din        (i_Din),
    .o_Dout_valid (o_Dout_valid),
    .o_Dout       (o_Dout),
    .o_Busy       (o_Busy),
    .o_Done       (o_Done),
    .o_Frame_idx  (o_Frame_idx),
    .o_Err        (o_Err)
`ifdef FRAME_CAPTURE_CTRL_MARKERS_EN
    ,
    .o_Sof        (o_Sof),
    .o_Eol        (o_Eol)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    i_Sys_clk = 1'b0;
    forever #5 i_Sys_clk = ~i_Sys_clk;
  end

  // Compare one value and record the result.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle worth of inputs.
  task automatic applyStimulus(input logic start, input logic stop, input logic [FCW-1:0] fnum,
                               input logic vsync, input logic valid, input logic [DW-1:0] din);
    i_Start     = start;
    i_Stop      = stop;
    i_Frame_num = fnum;
    i_Vsync     = vsync;
    i_Din_valid = valid;
    i_Din       = din;
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge i_Sys_clk);
    #1;
  endtask

  task automatic addVec(input logic start, input logic stop, input logic [FCW-1:0] fnum,
                        input logic vsync, input logic valid, input logic [DW-1:0] din,
                        input logic ev, input logic [DW-1:0] ed, input logic eb,
                        input logic edn, input logic [FCW-1:0] ei, input logic ee);
    vec_t v;
    v.start = start; v.stop = stop; v.fnum = fnum; v.vsync = vsync;
    v.valid = valid; v.din = din; v.expValid = ev; v.expDout = ed;
    v.expBusy = eb; v.expDone = edn; v.expIdx = ei; v.expErr = ee;
    vecs.push_back(v);
  endtask

  int validSeen;
  int doneSeen;

  initial begin
    passCount  = 0;
    checkCount = 0;
    i_Rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 16'h0);
    #1;
    checkOutput("reset_valid", {31'd0, o_Dout_valid}, 32'd0);
    checkOutput("reset_dout", {16'd0, o_Dout}, 32'd0);
    checkOutput("reset_busy", {31'd0, o_Busy}, 32'd0);
    checkOutput("reset_done", {31'd0, o_Done}, 32'd0);
    checkOutput("reset_idx", {24'd0, o_Frame_idx}, 32'd0);
    checkOutput("reset_err", {31'd0, o_Err}, 32'd0);
    repeat (2) @(posedge i_Sys_clk);
    #1;
    i_Rst = 1'b0;

    // Two-frame capture table: drop before vsync, forward from vsync, index
    // step after frame 0, drop the extra beat in ARM, done on beat 16.
    addVec(0, 0, 8'd0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 8'd0, 0);
    addVec(1, 0, 8'd2, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 8'd0, 0);
    addVec(0, 0, 8'd0, 0, 1, 16'h0011, 0, 16'h0000, 1, 0, 8'd0, 0);
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 8; p++) begin
        logic [DW-1:0] d;
        logic lastBeat;
        d = DW'(16'h0100 * (f + 1) + p);
        lastBeat = (p == 7);
        addVec(0, 0, 8'd0, (p == 0), 1, d, 1, d,
               !(lastBeat && f == 1), (lastBeat && f == 1),
               FCW'((lastBeat || f == 1) ? 1 : 0), 0);
      end
      addVec(0, 0, 8'd0, 0, 1, 16'h01ff, 0, DW'(16'h0100 * (f + 1) + 7),
             (f == 0), 0, 8'd1, 0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].fnum, vecs[i].vsync,
                    vecs[i].valid, vecs[i].din);
      tick();
      checkOutput($sformatf("vec%0d_valid", i), {31'd0, o_Dout_valid}, {31'd0, vecs[i].expValid});
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d_dout", i), {16'd0, o_Dout}, {16'd0, vecs[i].expDout});
      end
      checkOutput($sformatf("vec%0d_busy", i), {31'd0, o_Busy}, {31'd0, vecs[i].expBusy});
      checkOutput($sformatf("vec%0d_done", i), {31'd0, o_Done}, {31'd0, vecs[i].expDone});
      checkOutput($sformatf("vec%0d_idx", i), {24'd0, o_Frame_idx}, {24'd0, vecs[i].expIdx});
      checkOutput($sformatf("vec%0d_err", i), {31'd0, o_Err}, {31'd0, vecs[i].expErr});
    end

    // Short frame: vsync after 5 pixels restarts with the coincident beat as
    // pixel 0, error set, same index, 8 further pixels finish it.
    applyStimulus(1, 0, 8'd1, 0, 0, 16'h0);
    tick();
    checkOutput("short_busy_rise", {31'd0, o_Busy}, 32'd1);
    validSeen = 0;
    doneSeen  = 0;
    for (int p = 0; p < 5; p++) begin
      applyStimulus(0, 0, 8'd0, (p == 0), 1, DW'(16'h0050 + p));
      tick();
      validSeen += int'(o_Dout_valid);
      doneSeen  += int'(o_Done);
    end
    checkOutput("short_err_before", {31'd0, o_Err}, 32'd0);
    applyStimulus(0, 0, 8'd0, 1, 1, 16'h00a0);
    tick();
    checkOutput("short_restart_valid", {31'd0, o_Dout_valid}, 32'd1);
    checkOutput("short_restart_dout", {16'd0, o_Dout}, 32'h00a0);
    checkOutput("short_err_set", {31'd0, o_Err}, 32'd1);
    checkOutput("short_idx_same", {24'd0, o_Frame_idx}, 32'd0);
    for (int p = 1; p < 8; p++) begin
      applyStimulus(0, 0, 8'd0, 0, 1, DW'(16'h00a0 + p));
      tick();
      validSeen += int'(o_Dout_valid);
      doneSeen  += int'(o_Done);
    end
    checkOutput("short_done_last", {31'd0, o_Done}, 32'd1);
    checkOutput("short_busy_fall", {31'd0, o_Busy}, 32'd0);
    checkOutput("short_err_sticky", {31'd0, o_Err}, 32'd1);
    checkOutput("short_done_count", doneSeen, 32'd1);
    checkOutput("short_valid_count", validSeen, 32'd12);

    // Start and stop together in IDLE: stop wins.
    applyStimulus(1, 1, 8'd1, 0, 0, 16'h0);
    tick();
    checkOutput("startstop_busy", {31'd0, o_Busy}, 32'd0);
    checkOutput("startstop_err_held", {31'd0, o_Err}, 32'd1);

    // Stop after 3 pixels: busy falls next cycle, no done, beats dropped.
    applyStimulus(1, 0, 8'd3, 0, 0, 16'h0);
    tick();
    checkOutput("stop_err_cleared", {31'd0, o_Err}, 32'd0);
    for (int p = 0; p < 3; p++) begin
      applyStimulus(0, 0, 8'd0, (p == 0), 1, DW'(16'h0060 + p));
      tick();
    end
    applyStimulus(0, 1, 8'd0, 0, 1, 16'h0063);
    tick();
    checkOutput("stop_busy", {31'd0, o_Busy}, 32'd0);
    checkOutput("stop_valid", {31'd0, o_Dout_valid}, 32'd0);
    checkOutput("stop_done", {31'd0, o_Done}, 32'd0);
    validSeen = 0;
    for (int p = 0; p < 10; p++) begin
      applyStimulus(0, 0, 8'd0, (p == 2), 1, DW'(16'h0070 + p));
      tick();
      validSeen += int'(o_Dout_valid);
    end
    checkOutput("stop_dropped", validSeen, 32'd0);
    checkOutput("stop_dout_held", {16'd0, o_Dout}, 32'h0062);

    // Frame count 0 captures one frame; a second start while busy is ignored.
    applyStimulus(1, 0, 8'd0, 0, 0, 16'h0);
    tick();
    validSeen = 0;
    doneSeen  = 0;
    for (int p = 0; p < 12; p++) begin
      applyStimulus((p == 3), 0, 8'd5, (p == 0 || p == 9), 1, DW'(16'h0080 + p));
      tick();
      validSeen += int'(o_Dout_valid);
      doneSeen  += int'(o_Done);
      if (p == 7) begin
        checkOutput("zero_done_on_8th", {31'd0, o_Done}, 32'd1);
      end
    end
    checkOutput("zero_valid_count", validSeen, 32'd8);
    checkOutput("zero_done_count", doneSeen, 32'd1);
    checkOutput("zero_busy_end", {31'd0, o_Busy}, 32'd0);

    // Reset in mid-frame drops everything at once.
    applyStimulus(1, 0, 8'd2, 0, 0, 16'h0);
    tick();
    for (int p = 0; p < 3; p++) begin
      applyStimulus(0, 0, 8'd0, (p == 0), 1, DW'(16'h0090 + p));
      tick();
    end
    checkOutput("prerst_valid", {31'd0, o_Dout_valid}, 32'd1);
    #2;
    i_Rst = 1'b1;
    #1;
    checkOutput("rst_valid", {31'd0, o_Dout_valid}, 32'd0);
    checkOutput("rst_dout", {16'd0, o_Dout}, 32'd0);
    checkOutput("rst_busy", {31'd0, o_Busy}, 32'd0);
    checkOutput("rst_done", {31'd0, o_Done}, 32'd0);
    tick();
    i_Rst = 1'b0;
    applyStimulus(0, 0, 8'd0, 1, 1, 16'h0099);
    tick();
    checkOutput("postrst_idle_drop", {31'd0, o_Dout_valid}, 32'd0);

`ifdef FRAME_CAPTURE_CTRL_MARKERS_EN
    // Markers over a 2-frame capture.
    applyStimulus(1, 0, 8'd2, 0, 0, 16'h0);
    tick();
    validSeen = 0;
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 8; p++) begin
        applyStimulus(0, 0, 8'd0, (p == 0), 1, DW'(p));
        tick();
        if (o_Dout_valid) begin
          validSeen++;
          checkOutput($sformatf("sof_beat%0d", validSeen), {31'd0, o_Sof},
                      {31'd0, (validSeen == 1 || validSeen == 9)});
          checkOutput($sformatf("eol_beat%0d", validSeen), {31'd0, o_Eol},
                      {31'd0, (validSeen % 4 == 0)});
        end
      end
      applyStimulus(0, 0, 8'd0, 0, 0, 16'h0);
      tick();
    end
    checkOutput("marker_beats", validSeen, 32'd16);
`endif

    applyStimulus(0, 0, 8'd0, 0, 0, 16'h0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got %0d/%0d", passCount, checkCount);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/frame_capture_ctrl.md
# frame_capture_ctrl

Sequencing controller that sits in front of the simulation image dump and the capture path of the video FDMA bench. On a start command it waits for frame start, gates exactly N complete frames of IMAGE_WIDTH×IMAGE_HEIGHT pixels from a free-running pixel stream, and forwards them as a registered valid/data stream to the dump or capture sink. It counts pixels per line and lines per frame, detects short frames, and reports progress and completion.

## Interface
- DW, 16: pixel data width
- IMAGE_WIDTH, 640: pixels per line
- IMAGE_HEIGHT, 512: lines per frame
- FRAME_CNT_W, 8: width of frame-count request and index
- i_Sys_clk  input  1  system clock; all logic on rising edge
- i_Rst  input  1  reset, asynchronous, active-high
- i_Start  input  1  one-cycle capture request; ignored while o_Busy=1
- i_Stop  input  1  abort request; effective in any state
- i_Frame_num  input  FRAME_CNT_W  frames to capture; sampled when i_Start is accepted; 0 is treated as 1
- i_Vsync  input  1  one-cycle frame-start pulse
- i_Din_valid  input  1  pixel strobe
- i_Din  input  DW  pixel data
- o_Dout_valid  output  1  gated pixel strobe to the sink
- o_Dout  output  DW  gated pixel data
- o_Busy  output  1  controller not IDLE
- o_Done  output  1  one-cycle pulse when the last requested frame completes
- o_Frame_idx  output  FRAME_CNT_W  index of the frame being captured, starting at 0
- o_Err  output  1  sticky short-frame flag; cleared by accepted i_Start

## Operation
- States: IDLE, ARM, CAPTURE.
- IDLE: i_Start=1 latches target = max(i_Frame_num, 1), clears o_Frame_idx and o_Err, and moves to ARM.
- ARM: pixels are dropped. i_Vsync=1 moves to CAPTURE and clears the column and row counters. If i_Din_valid is also 1 in the i_Vsync cycle, that beat is pixel 0 and is forwarded.
- CAPTURE: every i_Din_valid beat is forwarded. The column counter wraps at IMAGE_WIDTH-1 and then increments the row.
- Frame completes on the beat where column=IMAGE_WIDTH-1 and row=IMAGE_HEIGHT-1.
  - If o_Frame_idx = target-1: o_Done pulses and the controller goes to IDLE.
  - Otherwise: o_Frame_idx increments and the controller goes to ARM.
- i_Vsync in CAPTURE before frame completion is a short frame:
  - o_Err is set.
  - Counters restart at 0 and the frame is recaptured with the same o_Frame_idx; the controller stays in CAPTURE.
  - A beat coincident with that i_Vsync is pixel 0 of the restarted frame.
- i_Vsync coinciding with the completing beat is treated as a completion, not a short frame. In that case, next frame's ARM observes no vsync in that cycle.
- Extra valid beats after completion (in ARM) are dropped.
- i_Stop has priority over everything: next state is IDLE, no o_Done pulse, o_Err holds, and o_Frame_idx holds. i_Start and i_Stop together in IDLE: stop wins and the start is ignored.
- Counter widths are $clog2(IMAGE_WIDTH) and $clog2(IMAGE_HEIGHT), with a minimum of 1. Comparisons are against the parameter minus 1, with no overflow.

## Timing
- o_Dout_valid and o_Dout are registered with 1-cycle latency from i_Din_valid and i_Din. o_Dout holds its last value when not valid.
- o_Done is asserted in the same cycle as the final o_Dout_valid of the last frame.
- o_Busy rises the cycle after i_Start is accepted. It falls in the cycle o_Done is asserted, or the cycle after i_Stop.
- Reset values: o_Dout_valid=0, o_Dout=0, o_Busy=0, o_Done=0, o_Frame_idx=0, o_Err=0, state=IDLE, counters=0.
- Reset asserted mid-frame immediately drops o_Dout_valid. No partial-frame completion is signalled.
- Full throughput: one pixel per cycle, back to back, with no stall input.

## Configuration
- FRAME_CAPTURE_CTRL_MARKERS_EN defined: adds outputs o_Sof (1 bit) and o_Eol (1 bit), registered with o_Dout_valid.
  - o_Sof is high on pixel 0 of each frame.
  - o_Eol is high on column IMAGE_WIDTH-1.
  - Both reset to 0.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

## Structure
- Package frame_capture_pkg: state enum (IDLE, ARM, CAPTURE) and a width helper for counter widths.
- Sub-module pix_line_counter holds the column/row counters with wrap and clear. It outputs last_col and last_pix.

## Test plan
All scenarios use IMAGE_WIDTH=4 and IMAGE_HEIGHT=2.
- i_Frame_num=2, i_Start, then vsync + 8 contiguous valid beats, twice -> 16 o_Dout_valid beats with 1-cycle latency. o_Frame_idx goes 0 then 1, o_Done pulses once on the 16th beat, and o_Err=0.
- Valid beats before the first vsync -> none forwarded. A beat coincident with vsync -> forwarded as pixel 0.
- Vsync after 5 pixels -> o_Err=1, the frame restarts with o_Frame_idx unchanged, and 8 further pixels complete it.
- i_Stop after 3 pixels -> o_Busy=0 next cycle, no o_Done, and later valid beats are dropped.
- i_Frame_num=0 -> exactly 8 pixels forwarded, then o_Done. A second i_Start while busy -> ignored.
- i_Rst asserted mid-frame -> all outputs are 0 immediately. With FRAME_CAPTURE_CTRL_MARKERS_EN defined, o_Sof is on beats 1 and 9, and o_Eol is on beats 4, 8, 12 and 16 of a 2-frame capture.
